// File: rtl/mem_latency_responder_pkg.sv
// -----------------------------------------------------------------------------
// mem_latency_responder_pkg
//   Shared definitions for the latency-modelling memory responder: interface
//   encodings, the out-of-range read pattern, FSM state encodings, the
//   data_out source select and the latched-request record.
// -----------------------------------------------------------------------------
package mem_latency_responder_pkg;

   localparam int unsigned WORD_W       = 32;
   localparam logic [31:0] MEM_START    = 32'h8000_2000;
   localparam logic        MEM_RW_READ  = 1'b1;
   localparam logic        MEM_RW_WRITE = 1'b0;
   localparam logic [31:0] MEM_BAD_DATA = 32'hDEAD_BEEF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_e;

   // Where data_out is taken from; it only changes on a completed read or reset.
   typedef enum logic [1:0] {
      OUT_ZERO  = 2'd0,
      OUT_ARRAY = 2'd1,
      OUT_BAD   = 2'd2
   } out_sel_e;

   typedef struct packed {
      logic [WORD_W-1:0] addr;
      logic [WORD_W-1:0] data;
      logic              rw;
   } req_t;

endpackage

// File: rtl/mem_latency_responder_word_array.sv
// -----------------------------------------------------------------------------
// mem_word_array
//   Single-port DEPTH_WORDS x 32 word store with synchronous write and a
//   registered read port. The read register only loads when re is high, so it
//   holds the last word read until the next read.
// Ports:
//   clock  - rising-edge clock
//   we     - write enable (addr/wdata committed on the edge)
//   re     - read enable (rdata loads mem[addr] on the edge)
//   addr   - word index
//   wdata  - write data
//   rdata  - registered read data
// -----------------------------------------------------------------------------
module mem_word_array
   import mem_latency_responder_pkg::*;
#(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned AW          = 10
) (
   input  logic              clock,
   input  logic              we,
   input  logic              re,
   input  logic [AW-1:0]     addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
   logic [WORD_W-1:0] rdata_q;
   logic [WORD_W-1:0] rdata_d;

   always_comb rdata_d = re ? mem_q[addr] : rdata_q;

   // NOTE: the storage has no reset so it maps onto RAM macros; contents
   // survive a responder reset, which the initiators rely on.
   always_ff @(posedge clock) begin
      if (we) mem_q[addr] <= wdata;
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/mem_latency_responder.sv
// -----------------------------------------------------------------------------
// mem_latency_responder
//   Responder for the word-addressed memory interface. Each accepted request
//   holds busy for LATENCY+1 cycles, then commits the write or updates
//   data_out. LATENCY = 0 completes every request on its own edge.
//   Out-of-range accesses are dropped (reads return MEM_BAD_DATA) and pulse
//   error for one cycle.
// Ports:
//   clock      - rising-edge clock
//   reset_n    - synchronous active-low reset (array contents are kept)
//   address    - byte address, bits [1:0] ignored
//   data_in    - write data
//   read_write - 1 = read, 0 = write
//   enable     - request valid
//   data_out   - read data, held until the next completed read
//   busy       - an accepted request is in flight
//   error      - one-cycle pulse after an out-of-range completion
// -----------------------------------------------------------------------------
module mem_latency_responder
   import mem_latency_responder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = MEM_START,
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] address,
   input  logic [31:0] data_in,
   input  logic        read_write,
   input  logic        enable,
   output logic [31:0] data_out,
   output logic        busy,
   output logic        error
);

   localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam int unsigned CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
   localparam bit          ZERO_LAT = (LATENCY == 0);

   state_e          state_q,   state_d;
   logic [CW-1:0]   count_q,   count_d;
   req_t            req_q,     req_d;
   logic            error_q,   error_d;
   out_sel_e        out_sel_q, out_sel_d;

   req_t            live;
   req_t            acc;
   logic            complete;
   logic [31:0]     offset;
   logic            in_range;
   logic            mem_we;
   logic            mem_re;
   logic [AW-1:0]   mem_idx;
   logic [31:0]     mem_rdata;

   assign live = '{addr: address, data: data_in, rw: read_write};

   // State register.
   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         count_q   <= '0;
         req_q     <= '0;
         error_q   <= 1'b0;
         out_sel_q <= OUT_ZERO;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         req_q     <= req_d;
         error_q   <= error_d;
         out_sel_q <= out_sel_d;
      end
   end

   // Next-state logic. With LATENCY = 0 the FSM never leaves IDLE.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latch).
      state_d = state_q;
      count_d = count_q;
      req_d   = req_q;
      case (state_q)
         IDLE: begin
            if (enable && !ZERO_LAT) begin
               req_d   = live;
               count_d = CW'(LATENCY - 1);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (count_q == '0) state_d = DONE;
            else               count_d = count_q - CW'(1);
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs and completion datapath. Zero latency completes straight from the
   // live inputs; otherwise the latched request completes in DONE.
   always_comb begin
      acc      = ZERO_LAT ? live : req_q;
      complete = ZERO_LAT ? (state_q == IDLE && enable) : (state_q == DONE);
      // Modulo-2^32 offset: addresses below BASE_ADDR wrap high and fail the
      // single unsigned compare.
      offset   = acc.addr - BASE_ADDR;
      in_range = offset < SPAN;
      mem_idx  = offset[AW+1:2];
      busy     = (state_q != IDLE);
      // Gated by reset_n so a reset edge never commits an access.
      mem_we   = reset_n && complete && in_range && (acc.rw == MEM_RW_WRITE);
      mem_re   = reset_n && complete && in_range && (acc.rw == MEM_RW_READ);
      error_d  = complete && !in_range;

      out_sel_d = out_sel_q;
      if (complete && acc.rw == MEM_RW_READ) out_sel_d = in_range ? OUT_ARRAY : OUT_BAD;

      case (out_sel_q)
         OUT_ARRAY: data_out = mem_rdata;
         OUT_BAD:   data_out = MEM_BAD_DATA;
         default:   data_out = 32'h0000_0000;
      endcase
   end

   assign error = error_q;

   mem_word_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clock (clock),
      .we    (mem_we),
      .re    (mem_re),
      .addr  (mem_idx),
      .wdata (acc.data),
      .rdata (mem_rdata)
   );

endmodule

// File: tb/tb_mem_latency_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_latency_responder
//   Lane 0 drives a LATENCY = 2 responder, lane 1 a LATENCY = 0 responder.
//   A transaction-level model predicts busy/error/data_out per lane, and a
//   negedge compare process checks both DUTs every cycle. Directed literal
//   checks pin the model.
// -----------------------------------------------------------------------------
module tb_mem_latency_responder;
   import mem_latency_responder_pkg::*;

   localparam logic [31:0] BASE  = 32'h8000_2000;
   localparam int          DEPTH = 1024;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic             reset_n;
   logic [1:0]       en, rw, busy, err;
   logic [1:0][31:0] addr, din, dout;

   mem_latency_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_lat2 (
      .clock(clock), .reset_n(reset_n), .address(addr[0]), .data_in(din[0]),
      .read_write(rw[0]), .enable(en[0]), .data_out(dout[0]), .busy(busy[0]), .error(err[0]));

   mem_latency_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_lat0 (
      .clock(clock), .reset_n(reset_n), .address(addr[1]), .data_in(din[1]),
      .read_write(rw[1]), .enable(en[1]), .data_out(dout[1]), .busy(busy[1]), .error(err[1]));

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          lat_of [2] = '{2, 0};
   bit          exp_busy [2];
   bit          exp_err  [2];
   logic [31:0] exp_dout [2];
   bit          known    [2];
   bit          inflight [2];
   int          remaining[2];
   bit          q_rw     [2];
   logic [31:0] q_addr   [2];
   logic [31:0] q_data   [2];
   logic [31:0] mm [int];

   task automatic model_complete(input int l, input bit r, input logic [31:0] a, input logic [31:0] d);
      logic [31:0] off;
      int key;
      off = a - BASE;
      if (off < 32'(4 * DEPTH)) begin
         key = l * DEPTH + int'(off >> 2);
         if (!r) mm[key] = d;
         else if (mm.exists(key)) begin
            exp_dout[l] = mm[key];
            known[l]    = 1'b1;
         end else known[l] = 1'b0;
      end else begin
         exp_err[l] = 1'b1;
         if (r) begin
            exp_dout[l] = 32'hDEAD_BEEF;
            known[l]    = 1'b1;
         end
      end
   endtask

   initial forever begin
      @(posedge clock);
      for (int l = 0; l < 2; l++) begin
         if (!reset_n) begin
            exp_busy[l] = 1'b0; exp_err[l] = 1'b0; exp_dout[l] = 32'h0;
            known[l]    = 1'b1; inflight[l] = 1'b0;
         end else begin
            exp_err[l] = 1'b0;
            if (inflight[l]) begin
               remaining[l]--;
               if (remaining[l] == 0) begin
                  model_complete(l, q_rw[l], q_addr[l], q_data[l]);
                  inflight[l] = 1'b0;
                  exp_busy[l] = 1'b0;
               end
            end else if (en[l]) begin
               if (lat_of[l] == 0) model_complete(l, rw[l], addr[l], din[l]);
               else begin
                  q_rw[l] = rw[l]; q_addr[l] = addr[l]; q_data[l] = din[l];
                  inflight[l]  = 1'b1;
                  remaining[l] = lat_of[l] + 1;
                  exp_busy[l]  = 1'b1;
               end
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit cmp_en = 1'b0;

   task automatic cmp_lane(input int l, input string tag);
      check({tag, " busy"},  {31'b0, busy[l]}, {31'b0, exp_busy[l]});
      check({tag, " error"}, {31'b0, err[l]},  {31'b0, exp_err[l]});
      if (known[l]) check({tag, " data_out"}, dout[l], exp_dout[l]);
   endtask

   always @(negedge clock) begin
      if (cmp_en) begin
         cmp_lane(0, "lat2");
         cmp_lane(1, "lat0");
      end
   end

   // ---------------- stimulus ----------------
   function automatic logic [31:0] pick_addr();
      int k;
      k = $urandom_range(0, 9);
      case (k)
         0:       return BASE + 32'(4 * DEPTH);
         1:       return BASE - 32'd4;
         2:       return 32'h8002_0000;
         default: return BASE + 32'(4 * $urandom_range(0, 31)) + 32'($urandom_range(0, 3));
      endcase
   endfunction

   // One lane-0 request; n = number of negedges busy was seen high.
   task automatic req0(input bit r, input logic [31:0] a, input logic [31:0] d,
                       input bit noisy, output int n);
      @(negedge clock);
      en[0] = 1'b1; rw[0] = r; addr[0] = a; din[0] = d;
      @(negedge clock);
      en[0] = 1'b0;
      n = 0;
      while (busy[0] === 1'b1 && n < 20) begin
         n++;
         if (noisy) begin
            en[0]   = 1'($urandom_range(0, 1));
            rw[0]   = 1'($urandom_range(0, 1));
            addr[0] = BASE + 32'(4 * $urandom_range(0, 31));
            din[0]  = $urandom;
         end
         @(negedge clock);
      end
      en[0] = 1'b0;
   endtask

   initial begin
      int n;
      reset_n = 1'b0; en = '0; rw = '0; addr = '0; din = '0;
      repeat (3) @(negedge clock);
      for (int l = 0; l < 2; l++) begin
         check("reset busy",     {31'b0, busy[l]}, 32'd0);
         check("reset error",    {31'b0, err[l]},  32'd0);
         check("reset data_out", dout[l],          32'h0);
      end
      reset_n = 1'b1;
      cmp_en  = 1'b1;

      // Basic write then read.
      req0(1'b0, BASE, 32'h1234_5678, 1'b0, n);
      check("write busy cycles", n, 3);
      req0(1'b1, BASE, 32'h0, 1'b0, n);
      check("read busy cycles", n, 3);
      check("read data", dout[0], 32'h1234_5678);

      // Fill 16 words with their index and read them back.
      for (int i = 0; i < 16; i++) req0(1'b0, BASE + 32'(4 * i), 32'(i), 1'b0, n);
      for (int i = 0; i < 16; i++) begin
         req0(1'b1, BASE + 32'(4 * i), 32'h0, 1'b0, n);
         check("fill read", dout[0], 32'(i));
         check("fill error", {31'b0, err[0]}, 32'd0);
      end

      // Out-of-range read and write.
      req0(1'b1, 32'h8002_0000, 32'h0, 1'b0, n);
      check("oor read error", {31'b0, err[0]}, 32'd1);
      check("oor read data", dout[0], 32'hDEAD_BEEF);
      @(negedge clock);
      check("oor error one cycle", {31'b0, err[0]}, 32'd0);
      req0(1'b0, 32'h8002_0000, 32'hFFFF_FFFF, 1'b0, n);
      check("oor write error", {31'b0, err[0]}, 32'd1);
      req0(1'b1, BASE, 32'h0, 1'b0, n);
      check("word0 intact", dout[0], 32'h0);

      // Range edges and a misaligned address.
      req0(1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h7777_0001, 1'b0, n);
      req0(1'b1, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 1'b0, n);
      check("last word data", dout[0], 32'h7777_0001);
      check("last word error", {31'b0, err[0]}, 32'd0);
      req0(1'b1, BASE - 32'd4, 32'h0, 1'b0, n);
      check("below base error", {31'b0, err[0]}, 32'd1);
      req0(1'b1, BASE + 32'd14, 32'h0, 1'b0, n);
      check("misaligned read", dout[0], 32'd3);

      // Inputs toggled while busy must not disturb the latched request.
      req0(1'b0, BASE + 32'd28, 32'hA5A5_0007, 1'b1, n);
      check("noisy busy cycles", n, 3);
      req0(1'b1, BASE + 32'd28, 32'h0, 1'b0, n);
      check("noisy write data", dout[0], 32'hA5A5_0007);

      // Reset during WAIT aborts the write.
      @(negedge clock);
      en[0] = 1'b1; rw[0] = 1'b0; addr[0] = BASE + 32'd20; din[0] = 32'hCAFE_F00D;
      @(negedge clock);
      en[0] = 1'b0;
      check("abort busy before reset", {31'b0, busy[0]}, 32'd1);
      reset_n = 1'b0;
      @(negedge clock);
      check("abort busy", {31'b0, busy[0]}, 32'd0);
      check("abort data_out", dout[0], 32'h0);
      reset_n = 1'b1;
      req0(1'b1, BASE + 32'd20, 32'h0, 1'b0, n);
      check("abort prior value", dout[0], 32'd5);

      // Randomised lane-0 traffic.
      repeat (150) begin
         req0(1'($urandom_range(0, 1)), pick_addr(), $urandom, $urandom_range(0, 3) == 0, n);
         check("random busy cycles", n, 3);
      end

      // Lane 1: back-to-back write/read pairs at zero latency.
      @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         en[1] = 1'b1; rw[1] = 1'b0; addr[1] = BASE + 32'(4 * (100 + i)); din[1] = 32'h5A00_0000 + 32'(i);
         @(negedge clock);
         rw[1] = 1'b1;
         @(negedge clock);
         check("lat0 pair read", dout[1], 32'h5A00_0000 + 32'(i));
      end
      en[1] = 1'b0;
      repeat (3) begin
         @(negedge clock);
         check("lat0 hold", dout[1], 32'h5A00_0007);
      end
      en[1] = 1'b1; rw[1] = 1'b1; addr[1] = 32'h8002_0000;
      @(negedge clock);
      en[1] = 1'b0;
      check("lat0 oor error", {31'b0, err[1]}, 32'd1);
      check("lat0 oor data", dout[1], 32'hDEAD_BEEF);
      @(negedge clock);
      check("lat0 error one cycle", {31'b0, err[1]}, 32'd0);

      // Randomised lane-1 traffic.
      repeat (300) begin
         en[1]   = ($urandom_range(0, 3) != 0);
         rw[1]   = 1'($urandom_range(0, 1));
         addr[1] = pick_addr();
         din[1]  = $urandom;
         @(negedge clock);
      end
      en[1] = 1'b0;
      repeat (3) @(negedge clock);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule
